// File: rtl/lab9_soc_key_input_if.sv
// Avalon-MM slave bus bundle for the lab9 key/switch parallel input port.
// The master modport is the interconnect side; the slave modport is the PIO side.
interface lab9_soc_key_input_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output read,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  read,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/lab9_soc_key_input.sv
// lab9_soc_key_input: Avalon-MM parallel input port for board KEY/SW inputs.
// Inputs pass through a two-flop synchroniser, then an edge detector feeds a
// sticky edge-capture register.  A level IRQ is raised for any capture bit
// enabled in the interrupt mask.
// Registers: 0 DATA (ro), 1 reserved (reads 0), 2 IRQ_MASK (rw),
//            3 EDGE_CAPTURE (read, write-1-to-clear).
// Optional feature macro: KEY_DEBOUNCE_EN adds a per-bit stability filter of
// DEBOUNCE_CYCLES clocks between the synchroniser and the rest of the logic.
module lab9_soc_key_input #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned EDGE_TYPE       = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   lab9_soc_key_input_if.slave  bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   // Reject out-of-range configurations at elaboration time.
   if ((WIDTH < 32'd1) || (WIDTH > 32'd32)) begin : g_width_check
      $error("lab9_soc_key_input: WIDTH must be 1..32");
   end
   if (EDGE_TYPE > 32'd2) begin : g_edge_check
      $error("lab9_soc_key_input: EDGE_TYPE must be 0, 1 or 2");
   end
   if ((DEBOUNCE_CYCLES < 32'd2) || (DEBOUNCE_CYCLES > 32'd65535)) begin : g_db_check
      $error("lab9_soc_key_input: DEBOUNCE_CYCLES must be 2..65535");
   end

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] level_s;
   logic [WIDTH-1:0] prev_r;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] clr_s;
   logic [WIDTH-1:0] irq_mask_r;
   logic [WIDTH-1:0] edge_capture_r;
   logic [1:0]       prime_r;
   logic             primed_s;
   logic             wr_s;
   logic             rd_s;
   logic [31:0]      rd_next_s;
   logic [31:0]      readdata_r;

   assign wr_s     = bus.chipselect && !bus.write_n;
   assign rd_s     = bus.chipselect && bus.read;
   assign primed_s = (prime_r == 2'd3);

   // Two-flop synchroniser for the asynchronous board inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= {WIDTH{1'b0}};
         sync2_r <= {WIDTH{1'b0}};
      end else begin
         sync1_r <= in_port;
         sync2_r <= sync1_r;
      end
   end

`ifdef KEY_DEBOUNCE_EN
   localparam logic [15:0] DB_LAST_C = 16'(DEBOUNCE_CYCLES - 32'd1);

   logic [WIDTH-1:0] deb_r;
   logic [15:0]      db_cnt_r [WIDTH];

   // Per-bit stability counter: the debounced bit follows sync2 only after it has differed for DEBOUNCE_CYCLES clocks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_r <= {WIDTH{1'b0}};
         for (int i = 0; i < int'(WIDTH); i++) begin
            db_cnt_r[i] <= 16'd0;
         end
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_r[i] != deb_r[i]) begin
               if (db_cnt_r[i] == DB_LAST_C) begin
                  deb_r[i]    <= sync2_r[i];
                  db_cnt_r[i] <= 16'd0;
               end else begin
                  db_cnt_r[i] <= db_cnt_r[i] + 16'd1;
               end
            end else begin
               db_cnt_r[i] <= 16'd0;
            end
         end
      end
   end

   assign level_s = deb_r;
`else
   assign level_s = sync2_r;
`endif

   // Level history for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_r <= {WIDTH{1'b0}};
      end else begin
         prev_r <= level_s;
      end
   end

   // Priming counter: holds off edge detection while the pipeline fills after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prime_r <= 2'd0;
      end else if (!primed_s) begin
         prime_r <= prime_r + 2'd1;
      end
   end

   // Edge term for the configured polarity, forced to zero until primed.
   always_comb begin
      edge_s = {WIDTH{1'b0}};
      if (primed_s) begin
         case (EDGE_TYPE)
            32'd0:   edge_s = level_s & ~prev_r;
            32'd1:   edge_s = ~level_s & prev_r;
            default: edge_s = level_s ^ prev_r;
         endcase
      end else begin
         edge_s = {WIDTH{1'b0}};
      end
   end

   // Write-one-to-clear mask for the capture register.
   always_comb begin
      clr_s = {WIDTH{1'b0}};
      if (wr_s && (bus.address == 2'd3)) begin
         clr_s = bus.writedata[WIDTH-1:0];
      end else begin
         clr_s = {WIDTH{1'b0}};
      end
   end

   // Sticky edge capture; a new edge wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture_r <= {WIDTH{1'b0}};
      end else begin
         edge_capture_r <= (edge_capture_r & ~clr_s) | edge_s;
      end
   end

   // Interrupt mask register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask_r <= {WIDTH{1'b0}};
      end else if (wr_s && (bus.address == 2'd2)) begin
         irq_mask_r <= bus.writedata[WIDTH-1:0];
      end
   end

   // Read mux over pre-edge register values, zero-extended to 32 bits.
   always_comb begin
      rd_next_s = 32'd0;
      case (bus.address)
         2'd0:    rd_next_s[WIDTH-1:0] = level_s;
         2'd2:    rd_next_s[WIDTH-1:0] = irq_mask_r;
         2'd3:    rd_next_s[WIDTH-1:0] = edge_capture_r;
         default: rd_next_s = 32'd0;
      endcase
   end

   // Registered read data, loaded only on a selected read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r <= 32'd0;
      end else if (rd_s) begin
         readdata_r <= rd_next_s;
      end
   end

   assign bus.readdata = readdata_r;
   assign irq          = |(edge_capture_r & irq_mask_r);

endmodule

// File: doc/lab9_soc_key_input.md
Name: lab9_soc_key_input

Overview:
- Avalon-MM slave parallel input port: the read-side counterpart of the SoC's output PIOs; it brings board inputs (KEY/SW) into the Nios II address space.
- Input path: 2-flop synchroniser, programmable edge capture, interrupt mask and a level IRQ to the CPU.
- Sits on the system interconnect beside the hex/LED output PIOs; the IRQ connects to the CPU interrupt controller.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 1, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16, stable-clock count required before a debounced bit changes; used only with KEY_DEBOUNCE_EN; range 2..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- read  in  1  read strobe, qualified by chipselect.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- in_port  in  WIDTH  asynchronous board inputs.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: clk and reset_n as Already decided. All of the following clear to 0: readdata, irq, irq_mask, edge_capture, both sync stages, prev, prime counter.
- Synchroniser:
  - Clock edge E0 samples in_port into sync1.
  - E1 copies sync1 into sync2.
  - level = sync2, or the debounced value when KEY_DEBOUNCE_EN is defined.
- Edge detect:
  - prev is level delayed by one clock.
  - Edge term per EDGE_TYPE: rising = level & ~prev; falling = ~level & prev; any = level ^ prev.
  - Without debounce, the capture bit sets on E2.
- Priming: a 2-bit prime counter runs for the first 3 clocks after reset release. Edge terms are forced to 0 until it saturates, so reset values never cause spurious captures.
- Register map (read data zero-extended above WIDTH):
  - addr 0 DATA: read returns level. Writes ignored.
  - addr 1: reads 0. Writes ignored.
  - addr 2 IRQ_MASK: read/write, bits [WIDTH-1:0].
  - addr 3 EDGE_CAPTURE: read returns capture bits. A write clears each bit whose writedata bit is 1.
- Write: occurs when chipselect && !write_n. Zero wait states; the register updates on that clock edge.
- Read latency:
  - Fixed at 1: readdata is loaded on the edge where chipselect && read, and holds until the next read.
  - A read with no write returns the pre-edge register value.
  - A read and an EDGE_CAPTURE clear in the same cycle returns the pre-clear value.
- Simultaneous set and clear of the same capture bit in one cycle: set wins, so the bit stays 1.
- irq = |(edge_capture & irq_mask), decoded combinationally from registers.
  - It asserts in the same cycle a masked capture bit sets.
  - It deasserts the cycle after the last masked bit is cleared or its mask bit is written 0.
- Asynchronous reset in mid-operation: all state clears immediately and priming restarts.

Optional Feature:
- Macro: KEY_DEBOUNCE_EN.
- Defined:
  - Each bit has a 16-bit counter.
  - While sync2 differs from the debounced value, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced bit takes sync2 and the counter clears.
  - level = debounced value; glitches shorter than DEBOUNCE_CYCLES clocks are rejected.
  - Debounced value and counters reset to 0.
- Undefined: level = sync2 and no counter logic is generated; all latencies are as stated above.

Test Plan:
- Reset check: in_port=4'hF through reset, then release.
  - Read addr 0 after 3 clocks -> 0x0000000F.
  - Read addr 3 -> 0.
  - irq stays 0 (no capture from priming).
- Falling-edge capture (EDGE_TYPE=1): write addr 2 = 0x4, then drive in_port 4'hF -> 4'hB.
  - edge_capture = 0x4 on the 3rd clock edge after the change.
  - irq=1 in that same cycle.
  - Read addr 3 -> 0x00000004 one cycle after read.
- Mask and clear:
  - Write addr 3 = 0x4 -> capture=0, irq drops the next cycle.
  - Repeat the edge with mask 0 -> capture=0x4, irq stays 0.
- Set/clear collision: schedule a new falling edge on bit 0 to land in the same cycle as a write of addr 3 = 0x1 -> bit 0 remains 1.
- Read latency and unused address:
  - Read addr 1 -> 0.
  - Back-to-back reads addr 0 then addr 2 -> readdata updates on consecutive cycles with the correct values.
- KEY_DEBOUNCE_EN with DEBOUNCE_CYCLES=16:
  - A 10-clock low pulse on bit 1 -> no change on addr 0, no capture.
  - A 20-clock low pulse -> addr 0 bit 1 goes 0 and capture bit 1 sets.
